aw_addr_queue: RTL and testbench

AW_ADDR_QUEUE -- requirements
Module: aw_addr_queue

---
 rtl/aw_addr_queue.sv | 117 +++++++++++
 tb/tb_aw_addr_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aw_addr_queue.sv
// AXI write-address tracker: holds accepted AW bursts, generates per-beat W addresses
// for the data head, and presents BIDs in AW order once each burst's data completes.
module aw_addr_queue #(
   parameter int ADDR_W = 32,
   parameter int ID_W   = 8,
   parameter int DEPTH  = 4
) (
   input  logic                       ACLK,
   input  logic                       ARESETn,
   input  logic [ADDR_W-1:0]          AWADDR,
   input  logic [ID_W-1:0]            AWID,
   input  logic [3:0]                 AWLEN,
   input  logic [2:0]                 AWSIZE,
   input  logic [1:0]                 AWBURST,
   input  logic                       AWVALID,
   output logic                       AWREADY,
   input  logic                       W_HS,
   input  logic                       WLAST,
   output logic [ADDR_W-1:0]          WADDR,
   output logic                       WADDR_VALID,
   output logic                       BVALID_REQ,
   output logic [ID_W-1:0]            BID,
   input  logic                       B_HS,
   output logic                       LEN_ERR,
   output logic [$clog2(DEPTH):0]     OUTSTANDING
);

   localparam int PW = $clog2(DEPTH);

   logic [PW:0]       aw_ptr, w_ptr, b_ptr;
   logic [ADDR_W-1:0] addr_mem  [DEPTH];
   logic [ID_W-1:0]   id_mem    [DEPTH];
   logic [3:0]        len_mem   [DEPTH];
   logic [2:0]        size_mem  [DEPTH];
   logic [1:0]        burst_mem [DEPTH];
   logic [3:0]        beat;

   logic              push, bypass, w_beat, w_done, b_pop;
   logic [ADDR_W-1:0] h_addr, offset, incr_addr, wrap_mask, beat_addr;
   logic [3:0]        h_len;
   logic [2:0]        h_size;
   logic [1:0]        h_burst;

   assign OUTSTANDING = aw_ptr - b_ptr;
   assign AWREADY     = OUTSTANDING != (PW+1)'(DEPTH);
   assign push        = AWVALID & AWREADY;
   assign bypass      = (aw_ptr == w_ptr) & push;
   assign WADDR_VALID = (aw_ptr != w_ptr) | push;
   assign w_beat      = W_HS & WADDR_VALID;
   assign w_done      = w_beat & WLAST;
   assign BVALID_REQ  = w_ptr != b_ptr;
   assign BID         = id_mem[b_ptr[PW-1:0]];
   assign b_pop       = B_HS & BVALID_REQ;

   // An empty data queue takes the burst straight from the AW channel.
   always_comb begin
      h_addr  = addr_mem[w_ptr[PW-1:0]];
      h_len   = len_mem[w_ptr[PW-1:0]];
      h_size  = size_mem[w_ptr[PW-1:0]];
      h_burst = burst_mem[w_ptr[PW-1:0]];
      if (bypass) begin
         h_addr  = AWADDR;
         h_len   = AWLEN;
         h_size  = AWSIZE;
         h_burst = AWBURST;
      end
   end

   always_comb begin
      offset    = ADDR_W'(beat) << h_size;
      incr_addr = h_addr + offset;
      wrap_mask = ((ADDR_W'(h_len) + ADDR_W'(1)) << h_size) - ADDR_W'(1);
      case (h_burst)
         2'b00:   beat_addr = h_addr;
         2'b10:   beat_addr = (h_addr & ~wrap_mask) | (incr_addr & wrap_mask);
         default: beat_addr = incr_addr;
      endcase
      WADDR = WADDR_VALID ? beat_addr : '0;
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         aw_ptr  <= '0;
         w_ptr   <= '0;
         b_ptr   <= '0;
         beat    <= '0;
         LEN_ERR <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_mem[i]  <= '0;
            id_mem[i]    <= '0;
            len_mem[i]   <= '0;
            size_mem[i]  <= '0;
            burst_mem[i] <= '0;
         end
      end else begin
         if (push) begin
            addr_mem[aw_ptr[PW-1:0]]  <= AWADDR;
            id_mem[aw_ptr[PW-1:0]]    <= AWID;
            len_mem[aw_ptr[PW-1:0]]   <= AWLEN;
            size_mem[aw_ptr[PW-1:0]]  <= AWSIZE;
            burst_mem[aw_ptr[PW-1:0]] <= AWBURST;
            aw_ptr <= aw_ptr + (PW+1)'(1);
         end
         if (w_done) begin
            w_ptr <= w_ptr + (PW+1)'(1);
            beat  <= '0;
         end else if (w_beat) begin
            beat  <= beat + 4'd1;
         end
         LEN_ERR <= w_done & (beat != h_len);
         if (b_pop) begin
            b_ptr <= b_ptr + (PW+1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_aw_addr_queue.sv
// Scoreboard bench: a queue-based model predicts every cycle's outputs; a monitor compares.
module tb_aw_addr_queue;

   localparam int DEPTH = 4;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic [31:0] AWADDR;
   logic [7:0]  AWID;
   logic [3:0]  AWLEN;
   logic [2:0]  AWSIZE;
   logic [1:0]  AWBURST;
   logic        AWVALID, AWREADY;
   logic        W_HS, WLAST;
   logic [31:0] WADDR;
   logic        WADDR_VALID;
   logic        BVALID_REQ;
   logic [7:0]  BID;
   logic        B_HS;
   logic        LEN_ERR;
   logic [2:0]  OUTSTANDING;

   aw_addr_queue #(.ADDR_W(32), .ID_W(8), .DEPTH(DEPTH)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWADDR(AWADDR), .AWID(AWID), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .W_HS(W_HS), .WLAST(WLAST), .WADDR(WADDR), .WADDR_VALID(WADDR_VALID),
      .BVALID_REQ(BVALID_REQ), .BID(BID), .B_HS(B_HS),
      .LEN_ERR(LEN_ERR), .OUTSTANDING(OUTSTANDING)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  id;
      logic [3:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } ent_t;

   typedef struct {
      bit          rst;
      bit          awready;
      bit          wvalid;
      logic [31:0] waddr;
      bit          bvalid;
      logic [7:0]  bid;
      bit          len_err;
      int          outst;
   } exp_t;

   // Model: bursts awaiting data, bursts awaiting response, current beat index.
   ent_t wq[$];
   ent_t bq[$];
   int   beat = 0;
   bit   lerr_pend = 1'b0;
   exp_t exp_q[$];

   int n_vec = 0;
   int n_bad = 0;

   function automatic logic [31:0] beat_addr(ent_t e, int b);
      longint unsigned base, bytes, total, lower;
      base  = longint'(e.addr);
      bytes = longint'(1) << e.size;
      total = (longint'(e.len) + 1) * bytes;
      case (e.burst)
         2'b00: return e.addr;
         2'b10: begin
            lower = (base / total) * total;
            return 32'(lower + ((base - lower + longint'(b) * bytes) % total));
         end
         default: return 32'(base + longint'(b) * bytes);
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      n_vec++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
      end
   endtask

   always @(negedge ACLK) begin : monitor
      exp_t e;
      #2;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("outstanding", 64'(OUTSTANDING), 64'(e.outst));
         chk("awready", 64'(AWREADY), 64'(e.awready));
         chk("waddr_valid", 64'(WADDR_VALID), 64'(e.wvalid));
         chk("waddr", 64'(WADDR), 64'(e.waddr));
         chk("bvalid_req", 64'(BVALID_REQ), 64'(e.bvalid));
         if (e.bvalid || e.rst) chk("bid", 64'(BID), 64'(e.bid));
         chk("len_err", 64'(LEN_ERR), 64'(e.len_err));
      end
   end

   task automatic do_reset();
      exp_t e;
      e.rst = 1'b1; e.awready = 1'b1; e.wvalid = 1'b0; e.waddr = '0;
      e.bvalid = 1'b0; e.bid = '0; e.len_err = 1'b0; e.outst = 0;
      @(negedge ACLK);
      ARESETn = 1'b0; AWVALID = 1'b0; W_HS = 1'b0; WLAST = 1'b0; B_HS = 1'b0;
      exp_q.push_back(e);
      @(negedge ACLK);
      exp_q.push_back(e);
      wq.delete(); bq.delete(); beat = 0; lerr_pend = 1'b0;
   endtask

   task automatic cyc(input bit awv, input logic [31:0] a, input logic [7:0] id,
                      input logic [3:0] len, input logic [2:0] sz, input logic [1:0] bu,
                      input bit whs, input bit wlast, input bit bhs);
      exp_t e;
      ent_t ne, head;
      bit   push, wv, wb;
      @(negedge ACLK);
      ARESETn = 1'b1;
      AWVALID = awv; AWADDR = a; AWID = id; AWLEN = len; AWSIZE = sz; AWBURST = bu;
      W_HS = whs; WLAST = wlast; B_HS = bhs;
      ne.addr = a; ne.id = id; ne.len = len; ne.size = sz; ne.burst = bu;
      e.rst     = 1'b0;
      e.outst   = wq.size() + bq.size();
      e.awready = e.outst != DEPTH;
      push      = awv && e.awready;
      wv        = (wq.size() > 0) || push;
      head      = ne;
      if (wq.size() > 0) head = wq[0];
      e.wvalid  = wv;
      e.waddr   = wv ? beat_addr(head, beat) : 32'h0;
      e.bvalid  = bq.size() > 0;
      e.bid     = 8'h0;
      if (e.bvalid) e.bid = bq[0].id;
      e.len_err = lerr_pend;
      exp_q.push_back(e);
      if (bhs && e.bvalid) void'(bq.pop_front());
      if (push) wq.push_back(ne);
      wb = whs && wv;
      lerr_pend = 1'b0;
      if (wb && wlast) begin
         lerr_pend = beat != int'(head.len);
         bq.push_back(wq.pop_front());
         beat = 0;
      end else if (wb) begin
         beat = (beat + 1) % 16;
      end
   endtask

   task automatic rnd_cyc();
      logic [31:0] a;
      logic [7:0]  id;
      logic [3:0]  len, hl;
      logic [2:0]  sz;
      logic [1:0]  bu;
      bit          awv, whs, wl, bhs;
      a   = $urandom;
      id  = 8'($urandom);
      bu  = 2'($urandom_range(0, 3));
      if (bu == 2'b10) len = 4'((1 << $urandom_range(1, 4)) - 1);
      else             len = 4'($urandom_range(0, 15));
      sz  = 3'($urandom_range(0, 7));
      awv = $urandom_range(0, 1) == 1;
      whs = $urandom_range(0, 9) < 6;
      bhs = $urandom_range(0, 9) < 5;
      hl  = len;
      if (wq.size() > 0) hl = wq[0].len;
      if (beat == int'(hl)) wl = $urandom_range(0, 7) != 0;
      else                  wl = $urandom_range(0, 15) == 0;
      cyc(awv, a, id, len, sz, bu, whs, wl, bhs);
   endtask

   task automatic idle();
      cyc(1'b0, 32'h0, 8'h0, 4'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      AWVALID = 1'b0; AWADDR = '0; AWID = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
      W_HS = 1'b0; WLAST = 1'b0; B_HS = 1'b0;
      do_reset();

      // INCR 0x1000 len 3 size 2, then response with the burst's ID
      cyc(1'b1, 32'h1000, 8'h5A, 4'd3, 3'd2, 2'b01, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 8'h0, 4'd0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 8'h0, 4'd0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 8'h0, 4'd0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 8'h0, 4'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      idle();

      // WRAP 0x1008 len 3 size 2
      cyc(1'b1, 32'h1008, 8'h21, 4'd3, 3'd2, 2'b10, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         cyc(1'b0, 32'h0, 8'h0, 4'd0, 3'd0, 2'd0, 1'b1, i == 3, 1'b0);
      cyc(1'b0, 32'h0, 8'h0, 4'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1);

      // fill to DEPTH, refuse one more, free one slot, B order follows AW order
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 32'h100 * i, 8'(8'h40 + i), 4'd0, 3'd0, 2'b01, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 32'h9000, 8'h99, 4'd0, 3'd0, 2'b01, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h9000, 8'h99, 4'd0, 3'd0, 2'b01, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 32'h9000, 8'h99, 4'd0, 3'd0, 2'b01, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++)
         cyc(1'b0, 32'h0, 8'h0, 4'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1);

      // bypass: push and complete a single-beat burst in one cycle
      cyc(1'b1, 32'h2000, 8'h77, 4'd0, 3'd2, 2'b01, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 8'h0, 4'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1);

      // early WLAST on len 3, then the next burst restarts at beat 0
      cyc(1'b1, 32'h3000, 8'h31, 4'd3, 3'd2, 2'b01, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 32'h4000, 8'h32, 4'd1, 3'd3, 2'b01, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 8'h0, 4'd0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 8'h0, 4'd0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 32'h0, 8'h0, 4'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1);

      // reset mid-burst with two entries, then a push on the first edge after release
      cyc(1'b1, 32'h5000, 8'h51, 4'd3, 3'd2, 2'b01, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 32'h6000, 8'h61, 4'd3, 3'd2, 2'b01, 1'b1, 1'b0, 1'b0);
      do_reset();
      cyc(1'b1, 32'h7000, 8'h71, 4'd0, 3'd2, 2'b00, 1'b0, 1'b0, 1'b0);
      idle();

      for (int i = 0; i < 1500; i++) begin
         if (i == 700) do_reset();
         rnd_cyc();
      end
      idle();

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge ACLK);
      #4;
      if (exp_q.size() > 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
